hazard_control: RTL and testbench
=================================

# hazard_control

Central pipeline hazard controller for the LC-3b five-stage pipeline. It sits beside the EX-stage operand forwarding logic and covers the hazards forwarding cannot resolve:
- load-use dependences;
- instruction and data memory wait states;
- taken-branch squashes, including draining a stale in-flight instruction fetch.

It drives the stall, bubble and flush controls of every pipeline register and keeps two small performance counters.

## Interface
Parameters:
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  system clock; one clock domain, all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- sr1_ID, sr2_ID  in  lc3b_reg  source registers of instruction in ID.
- sr1_used_ID, sr2_used_ID  in  1  corresponding source actually read.
- memread_EX  in  1  instruction in EX is a load (LDR/LDB/LDI).
- regwrite_EX  in  1  EX instruction writes a register.
- destreg_EX  in  lc3b_reg  EX destination register.
- dmem_read, dmem_write  in  1  MEM stage data request.
- dmem_resp  in  1  data memory response.
- imem_read  in  1  IF fetch request outstanding.
- imem_resp  in  1  instruction memory response.
- branch_taken_MEM  in  1  taken branch/jump resolved in MEM.
- stall_IF, stall_ID, stall_EX, stall_MEM  out  1  hold the PC and each pipeline register's contents.
- bubble_ID, bubble_EX, bubble_WB  out  1  load a NOP into IF/ID, ID/EX, MEM/WB.
- flush_IF_ID, flush_ID_EX, flush_EX_MEM  out  1  squash the register contents to a NOP.
- pc_redirect  out  1  load the PC with the branch target.
- imem_discard  out  1  drop the current imem_resp data.
- stall_cycles  out  CNT_W  count of cycles with stall_IF asserted.
- flush_count  out  CNT_W  count of taken-branch flushes.

## Operation
- States: RUN, DRAIN.
- Derived conditions:
  - dmem_busy = (dmem_read | dmem_write) & !dmem_resp.
  - imem_busy = imem_read & !imem_resp.
  - load_use = memread_EX & regwrite_EX & destreg_EX != 0 & ((sr1_used_ID & sr1_ID == destreg_EX) | (sr2_used_ID & sr2_ID == destreg_EX)).
- Unlisted outputs are 0. Priority is strictly top to bottom.
- In either state, if dmem_busy:
  - stall_IF, stall_ID, stall_EX, stall_MEM = 1 and bubble_WB = 1.
  - The state is unchanged. No flush, redirect or discard is issued.
- RUN with branch_taken_MEM:
  - flush_IF_ID, flush_ID_EX, flush_EX_MEM = 1 and pc_redirect = 1.
  - flush_count increments.
  - If imem_busy, the next state is DRAIN.
- RUN with load_use: stall_IF, stall_ID = 1 and bubble_EX = 1. This inserts exactly one bubble, because the load advances to MEM and forwarding then resolves the dependence.
- RUN with imem_busy: stall_IF = 1 and bubble_ID = 1.
- DRAIN:
  - stall_IF = 1 and bubble_ID = 1, so the redirected PC is held and no new fetch is accepted.
  - When imem_resp = 1: imem_discard = 1 and the next state is RUN.
  - branch_taken_MEM is ignored in DRAIN; the pipeline behind the flush holds only NOPs.
- stall_cycles increments every cycle that stall_IF = 1.
- Both counters wrap modulo 2^CNT_W.

## Timing
- All control outputs are combinational from the current state and current inputs, and take effect in the same cycle.
- The state and counters are registered on posedge clk.
- reset_n low, at any time including mid-DRAIN or mid-stall:
  - state = RUN and both counters = 0 immediately.
  - The outputs then follow the RUN rules with the current inputs.
- Branch arriving in the same cycle as imem_resp: no DRAIN; that response is used normally.
- Branch while imem_busy: DRAIN is entered next cycle and lasts until imem_resp, minimum 1 cycle.
- Counters update on the edge ending the qualifying cycle, so they are visible the next cycle.

## Structure
- Add to lc3b_types:
  - enum hazard_state_t {RUN, DRAIN};
  - lc3b_reg is already present and is reused here.
- One sub-module, hazard_perf_counter: a CNT_W wrapping counter with an increment enable, instantiated twice.
- Everything else lives in the hazard_control body.

## Test plan
- Load-use: memread_EX=1, regwrite_EX=1, destreg_EX=3, sr1_ID=3, sr1_used_ID=1 for one cycle -> stall_IF=stall_ID=bubble_EX=1 for exactly 1 cycle; stall_cycles=1 the next cycle.
- Load-use with destreg_EX=0, or sr2_used_ID=0 while sr2_ID matches -> no stall.
- dmem_read=1 with dmem_resp low for 4 cycles while load_use=1 and branch_taken_MEM=1 -> four cycles of all stalls plus bubble_WB; no flush or redirect; flush_count unchanged.
- branch_taken_MEM=1 with imem_read=1, imem_resp=0:
  - that cycle: all three flushes and pc_redirect.
  - next cycle and after: state DRAIN.
  - imem_resp asserted 3 cycles later -> imem_discard=1 in that cycle, back to RUN; flush_count=1.
- Branch in the same cycle as imem_resp=1 -> flushes asserted; state stays RUN; imem_discard=0.
- Reset mid-DRAIN:
  - drop reset_n asynchronously between edges -> state RUN and counters 0 before the next edge.
  - preload stall_cycles=0xFFFF, then one stall cycle -> counter wraps to 0.

Source files
------------

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b pipeline types
package lc3b_types;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } hazard_state_t;

endpackage

// File: rtl/hazard_perf_counter.sv
// rtl/hazard_perf_counter.sv - wrapping performance counter with increment enable
module hazard_perf_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_control.sv
// rtl/hazard_control.sv - LC-3b pipeline hazard controller
// Resolves load-use, memory wait-state and taken-branch hazards; drains stale fetches.
module hazard_control
    import lc3b_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  lc3b_reg          sr1_ID,
    input  lc3b_reg          sr2_ID,
    input  logic             sr1_used_ID,
    input  logic             sr2_used_ID,
    input  logic             memread_EX,
    input  logic             regwrite_EX,
    input  lc3b_reg          destreg_EX,
    input  logic             dmem_read,
    input  logic             dmem_write,
    input  logic             dmem_resp,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             branch_taken_MEM,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             stall_EX,
    output logic             stall_MEM,
    output logic             bubble_ID,
    output logic             bubble_EX,
    output logic             bubble_WB,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_EX_MEM,
    output logic             pc_redirect,
    output logic             imem_discard,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    hazard_state_t r_state;
    hazard_state_t w_next_state;
    logic          w_dmem_busy;
    logic          w_imem_busy;
    logic          w_load_use;
    logic          w_flush_inc;

    assign w_dmem_busy = (dmem_read | dmem_write) & ~dmem_resp;
    assign w_imem_busy = imem_read & ~imem_resp;
    assign w_load_use  = memread_EX & regwrite_EX & (destreg_EX != 3'd0) &
                         ((sr1_used_ID & (sr1_ID == destreg_EX)) |
                          (sr2_used_ID & (sr2_ID == destreg_EX)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        stall_IF     = 1'b0;
        stall_ID     = 1'b0;
        stall_EX     = 1'b0;
        stall_MEM    = 1'b0;
        bubble_ID    = 1'b0;
        bubble_EX    = 1'b0;
        bubble_WB    = 1'b0;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        flush_EX_MEM = 1'b0;
        pc_redirect  = 1'b0;
        imem_discard = 1'b0;
        w_flush_inc  = 1'b0;
        w_next_state = r_state;
        if (w_dmem_busy) begin
            // A data wait freezes the whole pipe, including any pending redirect.
            stall_IF  = 1'b1;
            stall_ID  = 1'b1;
            stall_EX  = 1'b1;
            stall_MEM = 1'b1;
            bubble_WB = 1'b1;
        end else if (r_state == DRAIN) begin
            stall_IF  = 1'b1;
            bubble_ID = 1'b1;
            if (imem_resp) begin
                imem_discard = 1'b1;
                w_next_state = RUN;
            end
        end else if (branch_taken_MEM) begin
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_EX_MEM = 1'b1;
            pc_redirect  = 1'b1;
            w_flush_inc  = 1'b1;
            if (w_imem_busy) begin
                w_next_state = DRAIN;
            end
        end else if (w_load_use) begin
            stall_IF  = 1'b1;
            stall_ID  = 1'b1;
            bubble_EX = 1'b1;
        end else if (w_imem_busy) begin
            stall_IF  = 1'b1;
            bubble_ID = 1'b1;
        end
    end

    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (stall_IF),
        .o_count (stall_cycles)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (w_flush_inc),
        .o_count (flush_count)
    );

endmodule

// File: tb/tb_hazard_control.sv
// tb/tb_hazard_control.sv - self-checking bench for hazard_control
module tb_hazard_control;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        reset_n;
    lc3b_reg     sr1_ID, sr2_ID, destreg_EX;
    logic        sr1_used_ID, sr2_used_ID, memread_EX, regwrite_EX;
    logic        dmem_read, dmem_write, dmem_resp, imem_read, imem_resp, branch_taken_MEM;
    logic        stall_IF, stall_ID, stall_EX, stall_MEM;
    logic        bubble_ID, bubble_EX, bubble_WB;
    logic        flush_IF_ID, flush_ID_EX, flush_EX_MEM, pc_redirect, imem_discard;
    logic [15:0] stall_cycles, flush_count;

    int checks = 0;
    int errors = 0;

    // Reference model: draining flag and unbounded event tallies.
    bit m_drain;
    int m_stalls;
    int m_flushes;

    always #5 clk = ~clk;

    hazard_control #(.CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .sr1_ID(sr1_ID), .sr2_ID(sr2_ID),
        .sr1_used_ID(sr1_used_ID), .sr2_used_ID(sr2_used_ID),
        .memread_EX(memread_EX), .regwrite_EX(regwrite_EX), .destreg_EX(destreg_EX),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
        .imem_read(imem_read), .imem_resp(imem_resp), .branch_taken_MEM(branch_taken_MEM),
        .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX), .stall_MEM(stall_MEM),
        .bubble_ID(bubble_ID), .bubble_EX(bubble_EX), .bubble_WB(bubble_WB),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .flush_EX_MEM(flush_EX_MEM),
        .pc_redirect(pc_redirect), .imem_discard(imem_discard),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    // {stall IF,ID,EX,MEM, bubble ID,EX,WB, flush IFID,IDEX,EXMEM, redirect, discard}
    wire [11:0] obs = {stall_IF, stall_ID, stall_EX, stall_MEM, bubble_ID, bubble_EX, bubble_WB,
                       flush_IF_ID, flush_ID_EX, flush_EX_MEM, pc_redirect, imem_discard};

    function automatic bit dbusy();
        return (dmem_read || dmem_write) && !dmem_resp;
    endfunction

    function automatic bit ibusy();
        return imem_read && !imem_resp;
    endfunction

    function automatic bit load_use();
        return memread_EX && regwrite_EX && destreg_EX != 0 &&
               ((sr1_used_ID && sr1_ID == destreg_EX) || (sr2_used_ID && sr2_ID == destreg_EX));
    endfunction

    function automatic logic [11:0] expect_outs();
        if (dbusy())           return 12'b1111_0010_0000;
        if (m_drain)           return {11'b1000_1000_000, imem_resp};
        if (branch_taken_MEM)  return 12'b0000_0001_1110;
        if (load_use())        return 12'b1100_0100_0000;
        if (ibusy())           return 12'b1000_1000_0000;
        return 12'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic set_idle();
        sr1_ID = 0; sr2_ID = 0; destreg_EX = 0;
        sr1_used_ID = 0; sr2_used_ID = 0; memread_EX = 0; regwrite_EX = 0;
        dmem_read = 0; dmem_write = 0; dmem_resp = 0;
        imem_read = 0; imem_resp = 0; branch_taken_MEM = 0;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle(input string tag, input bit do_chk);
        logic [11:0] e;
        bit          nd;
        #1;
        e = expect_outs();
        if (do_chk) begin
            chk({tag, ".outs"}, 32'(obs), 32'(e));
            chk({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_stalls & 16'hFFFF));
            chk({tag, ".flush_count"}, 32'(flush_count), 32'(m_flushes & 16'hFFFF));
        end
        nd = m_drain;
        if (!dbusy()) begin
            if (m_drain && imem_resp) nd = 0;
            else if (!m_drain && branch_taken_MEM) begin
                m_flushes++;
                if (ibusy()) nd = 1;
            end
        end
        @(posedge clk);
        m_drain = nd;
        if (e[11]) m_stalls++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_drain = 0; m_stalls = 0; m_flushes = 0;
    endtask

    initial begin
        set_idle();
        model_reset();
        reset_n = 0;
        #2;
        chk("reset.outs", 32'(obs), 32'h0);
        chk("reset.stall_cycles", 32'(stall_cycles), 32'h0);
        chk("reset.flush_count", 32'(flush_count), 32'h0);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);

        // Load-use on sr1: one bubble, then counter visible.
        memread_EX = 1; regwrite_EX = 1; destreg_EX = 3; sr1_ID = 3; sr1_used_ID = 1;
        cycle("lu", 1);
        chk("lu.exact", 32'(obs), 32'hC40);
        set_idle();
        cycle("lu_after", 1);
        chk("lu.count", 32'(stall_cycles), 32'd1);

        // No stall: destreg 0, or matching sr2 unused.
        memread_EX = 1; regwrite_EX = 1; destreg_EX = 0; sr1_ID = 0; sr1_used_ID = 1;
        cycle("lu_r0", 1);
        destreg_EX = 5; sr1_ID = 2; sr2_ID = 5; sr2_used_ID = 0;
        cycle("lu_sr2_unused", 1);
        set_idle();

        // Data wait dominates load-use and branch for 4 cycles.
        dmem_read = 1; memread_EX = 1; regwrite_EX = 1; destreg_EX = 4; sr2_ID = 4; sr2_used_ID = 1;
        branch_taken_MEM = 1;
        for (int i = 0; i < 4; i++) cycle("dwait", 1);
        chk("dwait.flush_count", 32'(flush_count), 32'd0);
        set_idle();
        cycle("dwait_end", 1);

        // Branch with fetch outstanding: drain 3 cycles, discard on response.
        branch_taken_MEM = 1; imem_read = 1;
        cycle("br_drain", 1);
        branch_taken_MEM = 0; imem_read = 0;
        cycle("drain0", 1);
        branch_taken_MEM = 1;
        cycle("drain1_br_ignored", 1);
        branch_taken_MEM = 0;
        cycle("drain2", 1);
        imem_read = 1; imem_resp = 1;
        cycle("drain_resp", 1);
        chk("drain.flush_count", 32'(flush_count), 32'd1);
        set_idle();
        cycle("post_drain", 1);
        chk("post_drain.run", 32'(obs), 32'h0);

        // Branch coinciding with the fetch response: no drain.
        branch_taken_MEM = 1; imem_read = 1; imem_resp = 1;
        cycle("br_resp", 1);
        set_idle();
        imem_resp = 1;
        cycle("br_resp_next", 1);
        chk("br_resp.no_discard", 32'(imem_discard), 32'd0);
        set_idle();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            sr1_ID = 3'($urandom_range(0, 3)); sr2_ID = 3'($urandom_range(0, 3));
            destreg_EX = 3'($urandom_range(0, 3));
            sr1_used_ID = 1'($urandom); sr2_used_ID = 1'($urandom);
            memread_EX = 1'($urandom); regwrite_EX = ($urandom_range(0, 3) != 0);
            dmem_read = ($urandom_range(0, 9) < 2); dmem_write = ($urandom_range(0, 9) == 0);
            dmem_resp = 1'($urandom);
            imem_read = ($urandom_range(0, 9) < 6); imem_resp = ($urandom_range(0, 9) < 4);
            branch_taken_MEM = ($urandom_range(0, 99) < 15);
            cycle("rand", 1);
        end
        set_idle();

        // Asynchronous reset mid-DRAIN.
        branch_taken_MEM = 1; imem_read = 1;
        cycle("pre_rst_br", 1);
        set_idle();
        cycle("pre_rst_drain", 1);
        #2;
        reset_n = 0;
        #1;
        model_reset();
        chk("async_rst.outs", 32'(obs), 32'h0);
        chk("async_rst.stall_cycles", 32'(stall_cycles), 32'h0);
        chk("async_rst.flush_count", 32'(flush_count), 32'h0);
        @(negedge clk);
        reset_n = 1;

        // Stall counter wrap at 2^16.
        imem_read = 1;
        for (int i = 0; i < 65535; i++) cycle("wrap_fill", 0);
        chk("wrap.ffff", 32'(stall_cycles), 32'hFFFF);
        cycle("wrap_last", 1);
        chk("wrap.zero", 32'(stall_cycles), 32'h0);
        set_idle();
        cycle("final", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
